// File: rtl/ste_avg_ctrl.sv
// Measurement sequencer for the IIR averager: clear, settle, average, capture.
// Optional sample watchdog enabled by defining STE_AVG_CTRL_TIMEOUT_EN.
module ste_avg_ctrl #(
`ifdef STE_AVG_CTRL_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 1000000,
`endif
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              cont_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_W-1:0]  settle_cnt_i,
    input  logic [CNT_W-1:0]  avg_len_i,
    input  logic              sample_vld_i,
    input  logic [DATA_W-1:0] avg_dout_i,
    output logic              avg_clr_o,
    output logic              avg_en_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_vld_o,
    input  logic              result_rdy_i,
    output logic              busy_o,
    output logic              ovr_o,
    output logic              err_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_AVERAGE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PIPE_LAT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cont_q, cont_d;
    logic [1:0]         mode_q, mode_d;
    logic               clr_q, clr_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               vld_q, vld_d;
    logic               ovr_q, ovr_d;
    logic [CNT_W:0]     cnt_nxt;
    logic [CNT_W-1:0]   avg_tgt;
    logic               tmo_hit;

    assign cnt_nxt = {1'b0, cnt_q} + 1'b1;
    assign avg_tgt = (avg_len_i == '0) ? CNT_W'(1) : avg_len_i;

`ifdef STE_AVG_CTRL_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        tmo_q;
    logic        in_cnt_state;

    assign in_cnt_state = (state_q == S_SETTLE) || (state_q == S_AVERAGE);
    assign tmo_hit = in_cnt_state && !sample_vld_i &&
                     (wd_q >= 32'(TIMEOUT_CYC - 1));

    // Reload on every strobe and whenever the state changes.
    always_comb begin
        wd_d = '0;
        if (in_cnt_state && (state_d == state_q) && !sample_vld_i)
            wd_d = wd_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_hit && !stop_i;
        end
    end

    assign err_timeout_o = tmo_q;
`else
    assign tmo_hit       = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        mode_d  = mode_q;
        res_d   = res_q;
        vld_d   = vld_q;
        ovr_d   = ovr_q;

        if (vld_q && result_rdy_i)
            vld_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d = S_CLEAR;
                    cont_d  = cont_i;
                    mode_d  = mode_i;
                    ovr_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = (settle_cnt_i == '0) ? S_AVERAGE : S_SETTLE;
            end
            S_SETTLE: begin
                if (sample_vld_i) begin
                    if (cnt_nxt >= {1'b0, settle_cnt_i}) begin
                        state_d = S_AVERAGE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_nxt[CNT_W-1:0];
                    end
                end
            end
            S_AVERAGE: begin
                if (sample_vld_i) begin
                    if (cnt_nxt >= {1'b0, avg_tgt}) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_nxt[CNT_W-1:0];
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q >= WAIT_LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_nxt[CNT_W-1:0];
                end
            end
            S_CAPTURE: begin
                // A same-cycle transfer frees the slot, so no overrun then.
                res_d   = avg_dout_i;
                vld_d   = 1'b1;
                if (vld_q && !result_rdy_i)
                    ovr_d = 1'b1;
                cnt_d   = '0;
                state_d = cont_q ? S_AVERAGE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit)
            state_d = S_IDLE;

        if (state_q != S_IDLE) begin
            if (stop_i) begin
                state_d = S_IDLE;
            end else if (mode_i != mode_q) begin
                state_d = S_CLEAR;
                mode_d  = mode_i;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        clr_d  = (state_d == S_CLEAR);
        en_d   = (state_d == S_AVERAGE) || (state_d == S_WAIT) ||
                 (state_d == S_CAPTURE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cont_q  <= 1'b0;
            mode_q  <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            mode_q  <= mode_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign avg_clr_o    = clr_q;
    assign avg_en_o     = en_q;
    assign busy_o       = busy_q;
    assign result_o     = res_q;
    assign result_vld_o = vld_q;
    assign ovr_o        = ovr_q;

endmodule
